// File: rtl/telemetry_rx.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_rx
// Purpose  : Receives the eBike telemetry UART stream (8N1), locates the
//            0xA5/0x5A packet header and reassembles the 12-bit battery,
//            current and torque words into held output registers.
// Ports    : clk      - system clock
//            rst_n    - synchronous active-low reset
//            RX       - serial input, idles high, asynchronous to clk
//            batt     - battery word from the last good packet
//            curr     - current word from the last good packet
//            torque   - torque word from the last good packet
//            vld      - one-cycle pulse when batt/curr/torque update
//            frm_err  - one-cycle pulse when a stop bit samples 0
//            busy     - high while the byte receiver is outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
module telemetry_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        frm_err,
    output logic        busy
);

    localparam int              CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   CNT_FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [2:0] P_HDR1 = 3'd0;
    localparam logic [2:0] P_HDR2 = 3'd1;
    localparam logic [2:0] P_BH   = 3'd2;
    localparam logic [2:0] P_BL   = 3'd3;
    localparam logic [2:0] P_CH   = 3'd4;
    localparam logic [2:0] P_CL   = 3'd5;
    localparam logic [2:0] P_TH   = 3'd6;
    localparam logic [2:0] P_TL   = 3'd7;

    logic          rx_meta, rx_s;
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          byte_rdy;
    logic          stop_bad;

    logic [2:0]    pkt, pkt_nxt;
    logic [3:0]    b_hi, c_hi, t_hi;
    logic [7:0]    b_lo, c_lo;
    logic          pkt_done;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (cnt == '0);

    // ---------------- byte receiver ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (tick)  state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (tick)  state_nxt = S_IDLE;
            default:            state_nxt = S_IDLE;
        endcase
    end

    // The byte is complete in shreg by the time the stop bit is sampled.
    always_comb begin
        byte_rdy = 1'b0;
        stop_bad = 1'b0;
        if (state == S_STOP && tick) begin
            byte_rdy = rx_s;
            stop_bad = !rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            frm_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            frm_err <= stop_bad;
            busy    <= (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (!rx_s) cnt <= CNT_HALF;
                end
                S_START: begin
                    if (tick) begin
                        cnt     <= CNT_FULL;
                        bit_idx <= 3'd0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= CNT_FULL;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (!tick) cnt <= cnt - 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // ---------------- packet assembler ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) pkt <= P_HDR1;
        else        pkt <= pkt_nxt;
    end

    always_comb begin
        pkt_nxt = pkt;
        if (stop_bad) begin
            pkt_nxt = P_HDR1;
        end else if (byte_rdy) begin
            case (pkt)
                P_HDR1:  if (shreg == 8'hA5) pkt_nxt = P_HDR2;
                P_HDR2: begin
                    if (shreg == 8'h5A)      pkt_nxt = P_BH;
                    else if (shreg != 8'hA5) pkt_nxt = P_HDR1;
                end
                P_TL:    pkt_nxt = P_HDR1;
                default: pkt_nxt = pkt + 3'd1;
            endcase
        end
    end

    always_comb begin
        pkt_done = byte_rdy && (pkt == P_TL);
    end

    // Held outputs only move on a completed packet; staging absorbs partials.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_hi   <= 4'd0;
            b_lo   <= 8'd0;
            c_hi   <= 4'd0;
            c_lo   <= 8'd0;
            t_hi   <= 4'd0;
            batt   <= 12'd0;
            curr   <= 12'd0;
            torque <= 12'd0;
            vld    <= 1'b0;
        end else begin
            vld <= pkt_done;
            if (byte_rdy) begin
                case (pkt)
                    P_BH: b_hi <= shreg[3:0];
                    P_BL: b_lo <= shreg;
                    P_CH: c_hi <= shreg[3:0];
                    P_CL: c_lo <= shreg;
                    P_TH: t_hi <= shreg[3:0];
                    P_TL: begin
                        batt   <= {b_hi, b_lo};
                        curr   <= {c_hi, c_lo};
                        torque <= {t_hi, shreg};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_telemetry_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_telemetry_rx
// Purpose  : Self-checking bench for telemetry_rx; expected packets are
//            queued as they are sent and compared when vld pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_telemetry_rx;

    localparam int BD = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX    = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        vld, frm_err, busy;

    telemetry_rx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .batt    (batt),
        .curr    (curr),
        .torque  (torque),
        .vld     (vld),
        .frm_err (frm_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [35:0] exp_q[$];
    int          vld_cnt  = 0;
    int          frm_cnt  = 0;
    logic        prev_vld = 1'b0;
    logic        busy_seen = 1'b0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (vld) begin
            vld_cnt++;
            check("vld_frm_excl", {35'd0, frm_err}, 36'd0);
            check("vld_width", {35'd0, prev_vld}, 36'd0);
            if (exp_q.size() == 0)
                check("vld_expected", 36'(exp_q.size()), 36'd1);
            else
                check("vld_data", {batt, curr, torque}, exp_q.pop_front());
        end
        if (frm_err) frm_cnt++;
        if (busy) busy_seen = 1'b1;
        prev_vld = vld;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BD) @(negedge clk);
        end
    endtask

    task automatic send_pkt(input logic [11:0] b, input logic [11:0] c,
                            input logic [11:0] t, input logic [3:0] junk);
        exp_q.push_back({b, c, t});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte({junk, b[11:8]}, 1'b1);
        send_byte(b[7:0], 1'b1);
        send_byte({junk, c[11:8]}, 1'b1);
        send_byte(c[7:0], 1'b1);
        send_byte({junk, t[11:8]}, 1'b1);
        send_byte(t[7:0], 1'b1);
    endtask

    task automatic idle(input int bits);
        RX = 1'b1;
        repeat (bits * BD) @(negedge clk);
    endtask

    int v0, f0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_batt", {24'd0, batt}, 36'd0);
        check("rst_curr", {24'd0, curr}, 36'd0);
        check("rst_torque", {24'd0, torque}, 36'd0);
        check("rst_vld", {35'd0, vld}, 36'd0);
        check("rst_frm_err", {35'd0, frm_err}, 36'd0);
        check("rst_busy", {35'd0, busy}, 36'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic packet
        v0 = vld_cnt; f0 = frm_cnt;
        send_pkt(12'h700, 12'hABC, 12'hEEE, 4'h0);
        idle(1);
        check("t1_vld_count", 36'(vld_cnt - v0), 36'd1);
        check("t1_frm_none", 36'(frm_cnt - f0), 36'd0);
        check("t1_hold", {batt, curr, torque}, 36'h700ABCEEE);

        // Three back-to-back packets, junk in ignored high nibbles
        v0 = vld_cnt;
        send_pkt(12'h001, 12'h555, 12'h0AA, 4'h0);
        send_pkt(12'h800, 12'h123, 12'hF0F, 4'h3);
        send_pkt(12'hFFF, 12'h000, 12'h7E1, 4'hC);
        idle(1);
        check("t2_vld_count", 36'(vld_cnt - v0), 36'd3);
        check("t2_hold", {batt, curr, torque}, 36'hFFF0007E1);

        // Header resync: 33 A5 A5 5A + payload
        v0 = vld_cnt;
        exp_q.push_back(36'h123456789);
        send_byte(8'h33, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
        send_byte(8'h04, 1'b1); send_byte(8'h56, 1'b1);
        send_byte(8'h07, 1'b1); send_byte(8'h89, 1'b1);
        idle(1);
        check("t3_vld_count", 36'(vld_cnt - v0), 36'd1);

        // Framing error on 4th byte, then clean packet
        v0 = vld_cnt; f0 = frm_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b0);
        idle(2);
        send_byte(8'h05, 1'b1); send_byte(8'h67, 1'b1);
        send_byte(8'h08, 1'b1); send_byte(8'h9A, 1'b1);
        idle(2);
        check("t4_frm_count", 36'(frm_cnt - f0), 36'd1);
        check("t4_no_vld", 36'(vld_cnt - v0), 36'd0);
        check("t4_hold", {batt, curr, torque}, 36'h123456789);
        send_pkt(12'h246, 12'h8AC, 12'hBDF, 4'h0);
        idle(1);
        check("t4_recover", 36'(vld_cnt - v0), 36'd1);

        // Short glitch on RX
        v0 = vld_cnt; f0 = frm_cnt;
        busy_seen = 1'b0;
        RX = 1'b0;
        repeat (BD / 4) @(negedge clk);
        idle(2);
        check("t5_busy_seen", {35'd0, busy_seen}, 36'd1);
        check("t5_busy_low", {35'd0, busy}, 36'd0);
        check("t5_no_frm", 36'(frm_cnt - f0), 36'd0);
        check("t5_no_vld", 36'(vld_cnt - v0), 36'd0);

        // Reset during byte 5
        v0 = vld_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h33, 1'b1);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BD) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_outputs", {batt, curr, torque}, 36'd0);
        check("t6_rst_busy", {35'd0, busy}, 36'd0);
        idle(3);
        send_pkt(12'h9AB, 12'hCDE, 12'h0F1, 4'h0);
        idle(1);
        check("t6_vld_count", 36'(vld_cnt - v0), 36'd1);
        check("t6_hold", {batt, curr, torque}, 36'h9ABCDE0F1);

        check("queue_empty", 36'(exp_q.size()), 36'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
